ext_irq_ctrl: RTL and testbench

External interrupt controller for the single-cycle LEGv8 core: the requesting side of the ExtIRQ/ExtIAck handshake. It collects N peripheral interrupt lines, edge-detects and latches them, masks them, priority-selects one, and holds ExtIRQ until the core acknowledges. It then blocks further requests until the core signals exception return (ERet), so interrupts never nest. Sits outside the processor top, beside the peripherals.

---
 rtl/irq_pkg.sv | 13 +
 rtl/ext_irq_ctrl_if.sv | 27 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/ext_irq_ctrl.sv | 106 ++++++++++
 tb/tb_ext_irq_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types for the external interrupt controller.
// Holds the handshake FSM state encoding and the source-count ceiling.
package irq_pkg;

    localparam int MAX_SRC = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/ext_irq_ctrl_if.sv
// Core-side ExtIRQ/ExtIAck/ERet handshake bundle.
// master = interrupt controller, slave = processor core.
interface ext_irq_ctrl_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = $clog2(N_SRC);

    logic            ExtIRQ;
    logic [ID_W-1:0] IrqId;
    logic            ExtIAck;
    logic            ERet;

    modport master (
        output ExtIRQ,
        output IrqId,
        input  ExtIAck,
        input  ERet
    );

    modport slave (
        input  ExtIRQ,
        input  IrqId,
        output ExtIAck,
        output ERet
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Bit 0 is the highest priority request.
module irq_prio_enc #(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-latches peripheral lines, masks,
// picks one and runs the non-nesting ExtIRQ/ExtIAck/ERet handshake.
module ext_irq_ctrl
    import irq_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             en_we,
    input  logic [N_SRC-1:0] en_wdata,
    ext_irq_ctrl_if.master   core,
    output logic [N_SRC-1:0] pending,
    output logic             busy
);

    if (N_SRC < 2 || N_SRC > MAX_SRC) begin : g_bad_n_src
        $error("ext_irq_ctrl: N_SRC out of range");
    end

    irq_state_e       state_q, state_d;
    logic             ext_irq_q, ext_irq_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] clr;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;

    assign rise = irq_in & ~prev_q;
    assign cand = pend_q & enable_q;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req   (cand),
        .valid (win_valid),
        .idx   (win_id)
    );

    // Handshake next-state; a fresh edge on the acked bit beats the clear.
    always_comb begin
        state_d   = state_q;
        ext_irq_d = ext_irq_q;
        irq_id_d  = irq_id_q;
        clr       = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d   = ASSERT;
                    ext_irq_d = 1'b1;
                    irq_id_d  = win_id;
                end
            end
            ASSERT: begin
                if (core.ExtIAck) begin
                    state_d   = SERVICE;
                    ext_irq_d = 1'b0;
                    clr       = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q;
                end
            end
            SERVICE: begin
                if (core.ERet) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                ext_irq_d = 1'b0;
            end
        endcase
        pend_d = (pend_q & ~clr) | rise;
    end

    // State, edge history, pending, enable; reset abandons any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ext_irq_q <= 1'b0;
            irq_id_q  <= '0;
            pend_q    <= '0;
            enable_q  <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            ext_irq_q <= ext_irq_d;
            irq_id_q  <= irq_id_d;
            pend_q    <= pend_d;
            prev_q    <= irq_in;
            if (en_we) begin
                enable_q <= en_wdata;
            end
        end
    end

    assign core.ExtIRQ = ext_irq_q;
    assign core.IrqId  = irq_id_q;
    assign pending     = pend_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: a vector table for the main flows
// plus hand sequences for mid-handshake reset and ignored pulses.
module tb_ext_irq_ctrl;

    localparam int N = 4;

    typedef struct {
        logic [3:0] irq;
        logic       we;
        logic [3:0] wd;
        logic       ack;
        logic       eret;
        logic       x_irq;
        logic [1:0] x_id;
        logic [3:0] x_pend;
        logic       x_busy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       en_we;
    logic [3:0] en_wdata;
    logic [3:0] pending;
    logic       busy;

    int checks;
    int failures;

    vec_t tbl[$];

    ext_irq_ctrl_if #(.N_SRC(N)) cif ();

    ext_irq_ctrl #(.N_SRC(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .core     (cif.master),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] irq, input logic we,
                         input logic [3:0] wd, input logic ack,
                         input logic eret);
        irq_in      = irq;
        en_we       = we;
        en_wdata    = wd;
        cif.ExtIAck = ack;
        cif.ERet    = eret;
    endtask

    task automatic expect_out(input string tag, input logic xi,
                              input logic [1:0] xid, input logic [3:0] xp,
                              input logic xb);
        chk({tag, ".ExtIRQ"}, 32'(cif.ExtIRQ), 32'(xi));
        chk({tag, ".IrqId"}, 32'(cif.IrqId), 32'(xid));
        chk({tag, ".pending"}, 32'(pending), 32'(xp));
        chk({tag, ".busy"}, 32'(busy), 32'(xb));
    endtask

    function automatic vec_t v(input logic [3:0] irq, input logic we,
                               input logic [3:0] wd, input logic ack,
                               input logic eret, input logic xi,
                               input logic [1:0] xid, input logic [3:0] xp,
                               input logic xb);
        vec_t r;
        r.irq = irq; r.we = we; r.wd = wd; r.ack = ack; r.eret = eret;
        r.x_irq = xi; r.x_id = xid; r.x_pend = xp; r.x_busy = xb;
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        //        irq      we wd       ak er  xI xId  xPend    xB
        // basic handshake
        tbl.push_back(v(4'b0000, 1, 4'b1111, 0, 0, 0, 2'd0, 4'b0000, 0));
        tbl.push_back(v(4'b0100, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0100, 0));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 0, 2'd2, 4'b0000, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 1, 0, 2'd2, 4'b0000, 0));
        // priority: bits 3 and 1 together
        tbl.push_back(v(4'b1010, 0, 4'b0000, 0, 0, 0, 2'd2, 4'b1010, 0));
        tbl.push_back(v(4'b1010, 0, 4'b0000, 0, 0, 1, 2'd1, 4'b1010, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 1, 0, 0, 2'd1, 4'b1000, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 1, 0, 2'd1, 4'b1000, 0));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 1, 2'd3, 4'b1000, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 1));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 1, 0, 2'd3, 4'b0000, 0));
        // masking, then enable write (old mask used on the write edge)
        tbl.push_back(v(4'b0100, 1, 4'b0001, 0, 0, 0, 2'd3, 4'b0100, 0));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 0, 2'd3, 4'b0100, 0));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 0, 2'd3, 4'b0100, 0));
        tbl.push_back(v(4'b0000, 1, 4'b0100, 0, 0, 0, 2'd3, 4'b0100, 0));
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 1));
        // no nesting: edge and stray ack during SERVICE
        tbl.push_back(v(4'b0000, 0, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 1));
        tbl.push_back(v(4'b0001, 1, 4'b1111, 0, 0, 0, 2'd2, 4'b0001, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 1, 0, 0, 2'd2, 4'b0001, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 1, 0, 2'd2, 4'b0001, 0));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 0, 1, 2'd0, 4'b0001, 1));
        // ack/re-edge collision on bit 0
        tbl.push_back(v(4'b0000, 0, 4'b0000, 0, 0, 1, 2'd0, 4'b0001, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 1, 0, 0, 2'd0, 4'b0001, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 1, 0, 2'd0, 4'b0001, 0));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 0, 1, 2'd0, 4'b0001, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 1));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0));
        // held level: no re-request
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0));
        tbl.push_back(v(4'b0001, 0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0));

        tick();
        expect_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].irq, tbl[i].we, tbl[i].wd, tbl[i].ack, tbl[i].eret);
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].x_irq, tbl[i].x_id,
                       tbl[i].x_pend, tbl[i].x_busy);
        end

        // ERet in IDLE and ack in IDLE are ignored; masked pending survives
        drive(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1);
        tick();
        expect_out("idle_ign", 1'b0, 2'd0, 4'b0010, 1'b0);
        drive(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick();
        expect_out("idle_ack", 1'b0, 2'd0, 4'b0010, 1'b0);

        // enable bit 1, then hold ASSERT across ERet and mask change
        drive(4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0);
        tick();
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        expect_out("asrt", 1'b1, 2'd1, 4'b0010, 1'b1);
        drive(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1);
        tick();
        expect_out("asrt_hold", 1'b1, 2'd1, 4'b0010, 1'b1);

        // reset mid-ASSERT
        reset = 1'b1;
        drive(4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0);
        tick();
        expect_out("rst_mid", 1'b0, 2'd0, 4'b0000, 1'b0);
        reset = 1'b0;
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        expect_out("post_rst_edge", 1'b0, 2'd0, 4'b0010, 1'b0);
        tick();
        expect_out("post_rst_masked", 1'b0, 2'd0, 4'b0010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
